// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: FSM state encoding and ALU opcodes.
// Imported by control_unit and instr_decoder.
package cpu_pkg;

    localparam int PC_W      = 5;
    localparam int WORD_W    = 8;
    localparam int RETIRED_W = 16;
    localparam int WAIT_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WAIT,
        WRITEBACK
    } state_t;

    typedef enum logic [2:0] {
        ADD   = 3'b000,
        SUB   = 3'b001,
        CMP   = 3'b010,
        MULT  = 3'b011,
        LOAD  = 3'b100,
        STORE = 3'b101,
        COMPL = 3'b110,
        SQRT  = 3'b111
    } opcode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: whether the ALU needs a WAIT phase and which
// destination (accumulator or data memory) receives the result.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       multi,
    output logic       ac_write,
    output logic       mem_write
);

    // Every opcode writes exactly one destination, so the two write flags never overlap.
    always_comb begin
        multi     = 1'b0;
        ac_write  = 1'b0;
        mem_write = 1'b0;
        case (opcode_t'(opcode))
            ADD, SUB, CMP, LOAD: ac_write = 1'b1;
            MULT: begin
                multi    = 1'b1;
                ac_write = 1'b1;
            end
            STORE, COMPL: mem_write = 1'b1;
            SQRT: begin
                multi     = 1'b1;
                mem_write = 1'b1;
            end
            default: begin
                multi     = 1'b0;
                ac_write  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches from the program ROM, launches the ALU, waits
// for multi-cycle results with a timeout, and issues one write enable per instruction.
module control_unit
    import cpu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  instruction,
    output logic [4:0]  rom_address,
    output logic [4:0]  mem_addr,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        ac_we,
    output logic        mem_we,
    output logic        busy,
    output logic        fault,
    output logic [15:0] retired
);

    // Last WAIT cycle count value before the timeout fires (counter starts at 0).
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_TIMEOUT - 1);

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [WORD_W-1:0]   ir;
    logic [WAIT_W-1:0]   wait_count;
    logic                dec_multi;
    logic                dec_ac_write;
    logic                dec_mem_write;

    instr_decoder u_decoder (
        .opcode    (ir[7:5]),
        .multi     (dec_multi),
        .ac_write  (dec_ac_write),
        .mem_write (dec_mem_write)
    );

    // IR only changes at the end of FETCH, so these stay stable DECODE..WRITEBACK.
    assign rom_address = pc;
    assign mem_addr    = ir[4:0];
    assign alu_op      = ir[7:5];

    // Outputs are registered: each strobe is set on the transition into the
    // state where it must be visible, and cleared by default every other cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            wait_count <= '0;
            fault      <= 1'b0;
            retired    <= '0;
            alu_start  <= 1'b0;
            ac_we      <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            ac_we     <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (run && !fault) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    ir    <= instruction;
                    state <= DECODE;
                end
                DECODE: begin
                    state     <= EXECUTE;
                    alu_start <= 1'b1;
                end
                EXECUTE: begin
                    if (dec_multi) begin
                        state      <= WAIT;
                        wait_count <= '0;
                    end else begin
                        state  <= WRITEBACK;
                        ac_we  <= dec_ac_write;
                        mem_we <= dec_mem_write;
                    end
                end
                WAIT: begin
                    // A completion in the final allowed cycle still wins over the timeout.
                    if (alu_done) begin
                        state  <= WRITEBACK;
                        ac_we  <= dec_ac_write;
                        mem_we <= dec_mem_write;
                    end else if (wait_count == WAIT_LAST) begin
                        state <= IDLE;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                WRITEBACK: begin
                    pc      <= pc + 1'b1;
                    retired <= retired + 1'b1;
                    if (run) begin
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a ROM model feeds instructions, expected
// writebacks are queued when programs are loaded and popped when a write enable fires.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  instruction;
    logic [4:0]  rom_address;
    logic [4:0]  mem_addr;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic        ac_we;
    logic        mem_we;
    logic        busy;
    logic        fault;
    logic [15:0] retired;

    logic [7:0] rom [32];

    typedef struct {
        logic       ac;
        logic       mem;
        logic [2:0] op;
        logic [4:0] addr;
        logic [4:0] pc;
    } wb_t;

    wb_t sb [$];
    wb_t mon_exp;
    int  vectors     = 0;
    int  miscompares = 0;
    logic [2:0] single_ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

    control_unit #(.ALU_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instruction (instruction),
        .rom_address (rom_address),
        .mem_addr    (mem_addr),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .ac_we       (ac_we),
        .mem_we      (mem_we),
        .busy        (busy),
        .fault       (fault),
        .retired     (retired)
    );

    assign instruction = rom[rom_address];

    always #5 clk = ~clk;

    // Reference: opcodes 000..100 target the accumulator, 101..111 the data memory.
    function automatic wb_t model_wb(input logic [4:0] pc, input logic [7:0] word);
        wb_t w;
        w.op   = word[7:5];
        w.addr = word[4:0];
        w.pc   = pc;
        w.ac   = (word[7:5] <= 3'd4);
        w.mem  = (word[7:5] > 3'd4);
        return w;
    endfunction

    function automatic int model_cycles(input logic [7:0] word);
        return (word[7:5] == 3'b011 || word[7:5] == 3'b111) ? 5 : 4;
    endfunction

    always @(negedge clk) begin
        if (ac_we === 1'b1 || mem_we === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: ac_we=%b mem_we=%b pc=%0d op=%b, required no write",
                         ac_we, mem_we, rom_address, alu_op);
            end else begin
                mon_exp = sb.pop_front();
                if ({ac_we, mem_we, alu_op, mem_addr, rom_address} !==
                    {mon_exp.ac, mon_exp.mem, mon_exp.op, mon_exp.addr, mon_exp.pc}) begin
                    miscompares++;
                    $display("[TB] FAIL writeback: got ac=%b mem=%b op=%b addr=%0d pc=%0d, required ac=%b mem=%b op=%b addr=%0d pc=%0d",
                             ac_we, mem_we, alu_op, mem_addr, rom_address,
                             mon_exp.ac, mon_exp.mem, mon_exp.op, mon_exp.addr, mon_exp.pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        run      = 1'b0;
        alu_done = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        run      = 1'b0;
        alu_done = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        step();
        step();
        vectors++;
        if ({busy, fault, alu_start, ac_we, mem_we} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: busy/fault/start/ac/mem=%b, required 00000",
                     {busy, fault, alu_start, ac_we, mem_we});
        end
        vectors++;
        if ({rom_address, retired, alu_op, mem_addr} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: pc=%0d retired=%0d op=%b addr=%0d, required all 0",
                     rom_address, retired, alu_op, mem_addr);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_load();
        rom[0] = 8'h8C;
        sb.push_back(model_wb(5'd0, 8'h8C));
        run = 1'b1;
        step();
        vectors++;
        if (rom_address !== 5'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_fetch: pc=%0d busy=%b, required 0/1", rom_address, busy);
        end
        step();
        vectors++;
        if ({alu_op, mem_addr} !== {3'b100, 5'd12}) begin
            miscompares++;
            $display("[TB] FAIL load_decode: op=%b addr=%0d, required 100/12", alu_op, mem_addr);
        end
        step();
        vectors++;
        if ({alu_start, ac_we, mem_we} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL load_execute: start/ac/mem=%b, required 100", {alu_start, ac_we, mem_we});
        end
        step();
        vectors++;
        if ({alu_start, ac_we, mem_we} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL load_writeback_c4: start/ac/mem=%b, required 010", {alu_start, ac_we, mem_we});
        end
        run = 1'b0;
        step();
        vectors++;
        if ({busy, rom_address, retired} !== {1'b0, 5'd1, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL load_done: busy=%b pc=%0d retired=%0d, required 0/1/1", busy, rom_address, retired);
        end
    endtask

    task automatic test_mult();
        rom[1] = 8'h7F;
        sb.push_back(model_wb(5'd1, 8'h7F));
        run = 1'b1;
        step();
        step();
        alu_done = 1'b1;
        step();
        vectors++;
        if (alu_start !== 1'b1 || alu_op !== 3'b011 || mem_addr !== 5'd31) begin
            miscompares++;
            $display("[TB] FAIL mult_execute: start=%b op=%b addr=%0d, required 1/011/31", alu_start, alu_op, mem_addr);
        end
        step();
        alu_done = 1'b0;
        vectors++;
        if ({busy, alu_start, ac_we, mem_we} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL mult_wait1: busy/start/ac/mem=%b, required 1000", {busy, alu_start, ac_we, mem_we});
        end
        step();
        step();
        alu_done = 1'b1;
        vectors++;
        if ({ac_we, mem_we} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mult_wait3: ac/mem=%b, required 00", {ac_we, mem_we});
        end
        step();
        alu_done = 1'b0;
        vectors++;
        if ({ac_we, mem_we} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL mult_writeback_c7: ac/mem=%b, required 10", {ac_we, mem_we});
        end
        run = 1'b0;
        step();
        vectors++;
        if ({busy, rom_address, retired} !== {1'b0, 5'd2, 16'd2}) begin
            miscompares++;
            $display("[TB] FAIL mult_done: busy=%b pc=%0d retired=%0d, required 0/2/2", busy, rom_address, retired);
        end
    endtask

    // Runs rom[0..n-1] back to back and checks total busy cycles against the model.
    task automatic run_program(input int n, input string name);
        int busy_cycles = 0;
        int want_cycles = 0;
        bit finished    = 0;
        for (int i = 0; i < n; i++) begin
            sb.push_back(model_wb(5'(i), rom[i]));
            want_cycles += model_cycles(rom[i]);
        end
        run = 1'b1;
        for (int c = 0; c < 400 && !finished; c++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
            if (retired == 16'(n - 1) && (ac_we === 1'b1 || mem_we === 1'b1)) run = 1'b0;
            if (retired == 16'(n) && busy === 1'b0) finished = 1;
        end
        run = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: retired=%0d busy=%b, required %0d/0", name, retired, busy, n);
        end
        vectors++;
        if (busy_cycles != want_cycles) begin
            miscompares++;
            $display("[TB] FAIL %s_cycles: got %0d, required %0d", name, busy_cycles, want_cycles);
        end
        vectors++;
        if (rom_address !== 5'(n) || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_end: pc=%0d pending=%0d, required %0d/0", name, rom_address, sb.size(), 5'(n));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            rom[i] = {single_ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31))};
        end
        run_program(32, "wrap");
        vectors++;
        if (retired !== 16'd32) begin
            miscompares++;
            $display("[TB] FAIL wrap_retired: got %0d, required 32", retired);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rom[0] = 8'hF3;
        run = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            vectors++;
            if ({busy, fault, ac_we, mem_we} !== 4'b1000) begin
                miscompares++;
                $display("[TB] FAIL timeout_wait%0d: busy/fault/ac/mem=%b, required 1000", i, {busy, fault, ac_we, mem_we});
            end
        end
        step();
        vectors++;
        if ({fault, busy, rom_address, retired} !== {1'b1, 1'b0, 5'd0, 16'd0}) begin
            miscompares++;
            $display("[TB] FAIL timeout_fault: fault=%b busy=%b pc=%0d retired=%0d, required 1/0/0/0",
                     fault, busy, rom_address, retired);
        end
        repeat (3) step();
        vectors++;
        if ({fault, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL fault_sticky: fault=%b busy=%b, required 1/0", fault, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_run_drop();
        do_reset();
        rom[0] = 8'h2A;
        sb.push_back(model_wb(5'd0, 8'h2A));
        run = 1'b1;
        step();
        step();
        step();
        run = 1'b0;
        step();
        vectors++;
        if ({ac_we, mem_we} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rundrop_writeback: ac/mem=%b, required 10", {ac_we, mem_we});
        end
        step();
        vectors++;
        if ({busy, rom_address, retired} !== {1'b0, 5'd1, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL rundrop_idle: busy=%b pc=%0d retired=%0d, required 0/1/1", busy, rom_address, retired);
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        rom[0] = 8'h05;
        rom[1] = 8'h60;
        sb.push_back(model_wb(5'd0, 8'h05));
        run = 1'b1;
        repeat (9) step();
        vectors++;
        if ({busy, rom_address, retired} !== {1'b1, 5'd1, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL rstwait_pre: busy=%b pc=%0d retired=%0d, required 1/1/1", busy, rom_address, retired);
        end
        rst      = 1'b1;
        alu_done = 1'b1;
        step();
        vectors++;
        if ({busy, fault, ac_we, mem_we, rom_address, retired} !== 25'd0) begin
            miscompares++;
            $display("[TB] FAIL rstwait_post: busy=%b fault=%b ac=%b mem=%b pc=%0d retired=%0d, required all 0",
                     busy, fault, ac_we, mem_we, rom_address, retired);
        end
        step();
        rst      = 1'b0;
        alu_done = 1'b0;
        run      = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rstwait_idle: busy=%b pending=%0d, required 0/0", busy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rom[0] = 8'hA5;
        rom[1] = 8'hC3;
        rom[2] = 8'h7E;
        rom[3] = 8'h05;
        rom[4] = 8'h49;
        rom[5] = 8'hFF;
        rom[6] = 8'h91;
        alu_done = 1'b1;
        run_program(7, "b2b");
        alu_done = 1'b0;
        vectors++;
        if (retired !== 16'd7 || fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_retired: retired=%0d fault=%b, required 7/0", retired, fault);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_mult();
        test_wrap();
        test_timeout();
        test_run_drop();
        test_reset_wait();
        test_back_to_back();
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter ALU_TIMEOUT, default 15, the maximum cycles spent in WAIT before a fault.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port run, input, 1, level enable for instruction execution.
REQ-005 The block SHALL have port instruction, input, 8, the program ROM word: [7:5] opcode, [4:0] operand address.
REQ-006 The block SHALL have port rom_address, output, 5, the program counter (PC) driven to the program ROM.
REQ-007 The block SHALL have port mem_addr, output, 5, the data-memory address, equal to IR[4:0].
REQ-008 The block SHALL have port alu_op, output, 3, equal to IR[7:5].
REQ-009 The block SHALL have port alu_start, output, 1, a one-cycle pulse that launches the ALU.
REQ-010 The block SHALL have port alu_done, input, 1, ALU completion strobe.
REQ-011 The block SHALL have port ac_we, output, 1, accumulator write enable.
REQ-012 The block SHALL have port mem_we, output, 1, data-memory write enable.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port fault, output, 1, sticky ALU-timeout flag.
REQ-015 The block SHALL have port retired, output, 16, count of completed instructions, wrapping at 65535->0.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, FETCH, DECODE, EXECUTE, WAIT, WRITEBACK.
REQ-017 Transitions SHALL be: IDLE->FETCH when run=1 and fault=0; FETCH->DECODE; DECODE->EXECUTE; EXECUTE->WAIT for opcodes 011 (mult) and 111 (sqrt), else EXECUTE->WRITEBACK; WAIT->WRITEBACK on alu_done; WRITEBACK->FETCH if run=1, else WRITEBACK->IDLE.
REQ-018 In FETCH, the block SHALL present the PC on rom_address and latch the instruction input into the instruction register (IR) at the end of that cycle; ROM read is combinational, zero latency.
REQ-019 alu_start SHALL pulse for exactly one cycle, in EXECUTE, for every opcode.
REQ-020 Single-cycle ops (000 add, 001 sub, 010 compare-equal, 100 load, 101 store, 110 complement) SHALL take 4 cycles, FETCH through WRITEBACK.
REQ-021 Multi-cycle ops SHALL take 4+N cycles, where N is the number of WAIT cycles up to and including the alu_done cycle.
REQ-022 alu_done SHALL be ignored outside WAIT.
REQ-023 alu_done asserted in the first WAIT cycle SHALL give N=1.
REQ-024 In WRITEBACK, ac_we SHALL be 1 for opcodes 000, 001, 010, 011 and 100, and mem_we SHALL be 1 for opcodes 101, 110 and 111.
REQ-025 At most one of ac_we and mem_we SHALL be high in any cycle, and both SHALL be 0 outside WRITEBACK.
REQ-026 In WRITEBACK, PC SHALL increment modulo 32 (31->0 wrap) and retired SHALL increment by 1.
REQ-027 mem_addr and alu_op SHALL be stable from DECODE through WRITEBACK.
REQ-028 A 4-bit counter SHALL count WAIT cycles.
REQ-029 If ALU_TIMEOUT cycles elapse in WAIT without alu_done, the block SHALL set fault and go to IDLE without writeback, leaving PC and retired unchanged.
REQ-030 Once fault is set, the block SHALL remain in IDLE until rst.
REQ-031 When run is deasserted mid-instruction, the current instruction SHALL complete and the block SHALL then enter IDLE.
REQ-032 When run and alu_done change in the same cycle, alu_done SHALL be honoured first.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL force state=IDLE, PC=0, IR=0, the wait counter to 0, fault=0 and retired=0, with all strobes low the next cycle.
REQ-034 rst SHALL take priority over all other inputs, including mid-WAIT and in WRITEBACK, where it suppresses the write enables.

Structure
REQ-035 Opcode constants (ADD, SUB, CMP, MULT, LOAD, STORE, COMPL, SQRT) and the state encoding SHALL live in a shared cpu package.
REQ-036 Opcode decoding (multi-cycle flag, AC-write flag, memory-write flag) SHALL be a combinational sub-module, instr_decoder.

Verification
REQ-037 The bench SHALL cover: rst, run=1, ROM word 0x8C at address 0 -> alu_op=100, mem_addr=12, ac_we pulse at cycle 4, PC=1, retired=1.
REQ-038 The bench SHALL cover: opcode 0x7F with alu_done 3 cycles after alu_start -> WAIT lasts 3 cycles, ac_we in cycle 7, mem_we=0.
REQ-039 The bench SHALL cover: 32 single-cycle instructions -> PC wraps 31->0 and retired=32.
REQ-040 The bench SHALL cover: opcode 0xF3 with alu_done never asserted -> fault=1 after 15 WAIT cycles, no mem_we, busy=0, PC unchanged.
REQ-041 The bench SHALL cover: run dropped during EXECUTE -> WRITEBACK still occurs, then IDLE, PC advanced by 1.
REQ-042 The bench SHALL cover: rst asserted during WAIT -> next cycle IDLE, PC=0, retired=0, and no write enable.
